pll_reset_sequencer: RTL and testbench

- Drives the reset input of a PLL wrapper and consumes its locked output: the controlling end of the PLL rst/locked interface.
- Pulses PLL reset, waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing the system reset.
- Tears down and re-sequences whenever lock is lost after release.
- Sits between the board reset/refclk and the Nios/audio clock-domain reset logic.

---
 rtl/pll_seq_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 33 +++
 rtl/pll_reset_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared types and default timing for the PLL reset sequencer.
//   state_e    : sequencer state, 3-bit encoding (unused codes recover in RTL)
//   DEF_*      : default timing in refclk cycles (50 MHz refclk)
//   cnt_width  : bits needed to hold a given cycle count
// -----------------------------------------------------------------------------
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } state_e;

  // Smallest width w with 2**w > cycles, never less than 1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = 1;
    while ((cycles >> w) != 0) w++;
    return w;
  endfunction

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 50;     // 1 us
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;  // 1 ms
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 7;
  // The lock timeout is the largest of the three default windows.
  localparam int unsigned DEF_CNT_W = cnt_width(DEF_LOCK_TIMEOUT_CYCLES);

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for signals asynchronous to clk. Each bit is
// synchronized independently, so only use WIDTH > 1 for unrelated bits.
//   clk : destination clock
//   rst : asynchronous active-high reset, both stages clear to 0
//   d   : asynchronous input
//   q   : synchronized output
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make meta and q shift as a true two-stage
  // pipeline; blocking ones would collapse them into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Controls a PLL's reset and watches its lock. Pulses pll_rst, waits for lock
// with a timeout and bounded retries, demands a stable lock window, then
// releases the system reset. A lock loss while running tears everything down
// and restarts the sequence.
//   refclk      : free-running reference clock (only clock)
//   rst         : asynchronous active-high reset
//   pll_locked  : PLL lock, asynchronous to refclk
//   clear_fail  : one-cycle request to leave FAILED
//   pll_rst     : PLL reset, active-high
//   sys_reset   : system reset, active-high, low only in RUN
//   ready       : high only in RUN
//   fail        : high only in FAILED
//   lock_lost   : one-cycle pulse when lock drops in RUN
//   retry_count : lock timeouts in the current sequence
//   lost_count  : lock-loss events since rst, saturating at 255
// -----------------------------------------------------------------------------
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clear_fail,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic [7:0] lost_count
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  logic             lk;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;
  logic             lost_evt;
  logic             pll_rst_d, sys_reset_d, ready_d, fail_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // State, counter and output registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst   <= pll_rst_d;
      sys_reset <= sys_reset_d;
      ready     <= ready_d;
      fail      <= fail_d;
      lock_lost <= lost_evt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    retry_d  = retry_q;
    lost_d   = lost_q;
    lost_evt = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock is tested first so a lock arriving on the timeout cycle wins.
        if (lk) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = FAILED;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + 4'd1;
          end
        end
      end
      STABLE: begin
        // A glitch restarts the lock wait without spending a retry.
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!lk) begin
          state_d  = RESET_PLL;
          cnt_d    = '0;
          lost_evt = 1'b1;
          lost_d   = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end
      end
      FAILED: begin
        cnt_d = cnt_q;
        if (clear_fail) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs change on
  // the same edge as the state they describe.
  always_comb begin
    pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAILED);
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fail_d      = (state_d == FAILED);
  end

  assign retry_count = retry_q;
  assign lost_count  = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Directed bench for pll_reset_sequencer with RST_PULSE_CYCLES=4,
// LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2. The stimulus
// process pushes every expected output change (cycle + output vector) into a
// queue; a monitor pops and compares whenever the outputs change.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  typedef struct packed {
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry;
    logic [7:0] lost;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } exp_t;

  localparam obs_t RST_V = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       clear_fail;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [7:0] lost_count;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  obs_t prev;
  obs_t m;
  exp_t exp_q[$];

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .CNT_W               (16)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .clear_fail  (clear_fail),
    .pll_rst     (pll_rst),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .fail        (fail),
    .lock_lost   (lock_lost),
    .retry_count (retry_count),
    .lost_count  (lost_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  function automatic obs_t obs_now();
    return {pll_rst, sys_reset, ready, fail, lock_lost, retry_count, lost_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int at);
    exp_t e;
    e.cyc = at;
    e.v   = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge refclk);
  endtask

  // Expected changes after pll_locked drops at cycle c while in RUN.
  task automatic expect_loss(input int c);
    m.pll_rst   = 1'b1;
    m.sys_reset = 1'b1;
    m.ready     = 1'b0;
    m.lock_lost = 1'b1;
    m.lost      = (m.lost == 8'hFF) ? 8'hFF : m.lost + 8'd1;
    push(c + 3);
    m.lock_lost = 1'b0;
    push(c + 4);
    m.pll_rst = 1'b0;
    push(c + 7);
  endtask

  task automatic expect_run(input int at);
    m.sys_reset = 1'b0;
    m.ready     = 1'b1;
    m.retry     = 4'd0;
    push(at);
  endtask

  // Monitor: every output change must match the next queued expectation.
  initial begin
    obs_t cur;
    exp_t e;
    forever begin
      @(negedge refclk);
      if (mon_en) begin
        cur = obs_now();
        if (cur !== prev) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_change at cycle %0d: got %h, nothing expected", cyc, cur);
          end else begin
            e = exp_q.pop_front();
            check("event_cycle", 32'(cyc), 32'(e.cyc));
            check("event_value", 32'(cur), 32'(e.v));
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst        = 1'b1;
    pll_locked = 1'b0;
    clear_fail = 1'b0;
    repeat (3) @(negedge refclk);
    check("reset_state", 32'(obs_now()), 32'(RST_V));
    prev   = obs_now();
    m      = RST_V;
    mon_en = 1'b1;

    // 1: power-up sequence, lock 10 cycles after pll_rst falls.
    c   = cyc;
    rst = 1'b0;
    m.pll_rst = 1'b0;
    push(c + 4);
    wait_to(c + 14);
    pll_locked = 1'b1;
    expect_run(c + 25);
    wait_to(c + 25);

    // 4: repeated lock loss in RUN, lost_count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      c = cyc;
      pll_locked = 1'b0;
      expect_loss(c);
      wait_to(c + 2);
      pll_locked = 1'b1;
      expect_run(c + 16);
      wait_to(c + 16);
    end
    check("lost_saturated", 32'(lost_count), 32'd255);

    // 3: lock glitch at stable count 5 restarts the lock wait.
    c = cyc;
    pll_locked = 1'b0;
    expect_loss(c);
    wait_to(c + 2);
    pll_locked = 1'b1;
    wait_to(c + 11);
    pll_locked = 1'b0;
    wait_to(c + 13);
    pll_locked = 1'b1;
    expect_run(c + 24);
    wait_to(c + 24);

    // 6: lock seen on the exact timeout cycle wins over the retry.
    c = cyc;
    pll_locked = 1'b0;
    expect_loss(c);
    wait_to(c + 24);
    pll_locked = 1'b1;
    expect_run(c + 35);
    wait_to(c + 35);

    // 2: no lock -> two retries then FAILED; clear_fail restarts.
    c = cyc;
    pll_locked = 1'b0;
    expect_loss(c);
    m.pll_rst = 1'b1; m.retry = 4'd1; push(c + 27);
    m.pll_rst = 1'b0;                 push(c + 31);
    m.pll_rst = 1'b1; m.retry = 4'd2; push(c + 51);
    m.pll_rst = 1'b0;                 push(c + 55);
    m.pll_rst = 1'b1; m.fail  = 1'b1; push(c + 75);
    wait_to(c + 80);
    m.fail = 1'b0; m.retry = 4'd0;    push(c + 81);
    m.pll_rst = 1'b0;                 push(c + 85);
    clear_fail = 1'b1;
    wait_to(c + 81);
    clear_fail = 1'b0;
    // clear_fail while waiting for lock must be ignored.
    wait_to(c + 87);
    clear_fail = 1'b1;
    wait_to(c + 88);
    clear_fail = 1'b0;
    m.pll_rst = 1'b1; m.retry = 4'd1; push(c + 105);
    m.pll_rst = 1'b0;                 push(c + 109);
    m.pll_rst = 1'b1; m.retry = 4'd2; push(c + 129);
    m.pll_rst = 1'b0;                 push(c + 133);
    m.pll_rst = 1'b1; m.fail  = 1'b1; push(c + 153);
    wait_to(c + 160);

    // 5a: async reset while FAILED.
    @(posedge refclk);
    #2;
    rst = 1'b1;
    m   = RST_V;
    push(cyc);
    #1;
    check("async_rst_failed", 32'(obs_now()), 32'(RST_V));
    c = cyc;
    wait_to(c + 3);
    c   = cyc;
    rst = 1'b0;
    m.pll_rst = 1'b0;
    push(c + 4);
    wait_to(c + 5);
    pll_locked = 1'b1;
    wait_to(c + 10);

    // 5b: async reset while STABLE, then a clean restart to RUN.
    @(posedge refclk);
    #2;
    rst = 1'b1;
    m   = RST_V;
    push(cyc);
    #1;
    check("async_rst_stable", 32'(obs_now()), 32'(RST_V));
    c = cyc;
    wait_to(c + 3);
    c   = cyc;
    rst = 1'b0;
    m.pll_rst = 1'b0;
    push(c + 4);
    expect_run(c + 13);
    wait_to(c + 20);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
